lc3b_wb_cache: RTL and testbench
================================

Name: lc3b_wb_cache

Overview:
- Parametrised write-back, write-allocate, direct-mapped cache between the LC-3b cpu memory port and physical memory.
- Each line is one lc3b_pmem_line: 128 bits, 8 words, 16 bytes.
- Set count is set by a parameter.
- Drops between cpu (mem_*) and physical memory (pmem_*) ports in the mp3 top level, with no change to either port list.

Parameters:
- NUM_SETS, 8, number of lines; power of two, 2..64.
- IDX_W, $clog2(NUM_SETS), index width; derived, do not override.
- TAG_W, 12-IDX_W, tag width; derived (16 address bits minus 4 offset bits minus index).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_read  in  1  cpu read request; held until mem_resp.
- mem_write  in  1  cpu write request; held until mem_resp.
- mem_byte_enable  in  2  lc3b_mem_wmask; [0] low byte, [1] high byte.
- mem_address  in  16  lc3b_word byte address.
- mem_wdata  in  16  lc3b_word write data.
- mem_resp  out  1  one-cycle completion pulse to cpu.
- mem_rdata  out  16  read word; valid while mem_resp=1.
- pmem_resp  in  1  physical memory completion.
- pmem_rdata  in  128  lc3b_pmem_line fill data.
- pmem_read  out  1  line read request.
- pmem_write  out  1  line write request.
- pmem_address  out  16  line-aligned address; bits [3:0] always 0.
- pmem_wdata  out  128  victim line data.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; all valid and dirty bits clear.
  - mem_resp, pmem_read and pmem_write are 0; pmem_address and pmem_wdata are 0.
  - Reset mid-miss abandons the pmem transaction. pmem_read/pmem_write drop the next cycle, and a late pmem_resp is ignored.
- Address split: offset=[3:0], word select=[3:1], index=[3+IDX_W:4], tag=[15:4+IDX_W].
- Hit = valid[index] and tag match, with a request asserted.
- IDLE, hit read:
  - mem_resp=1 combinationally in the same cycle.
  - mem_rdata = selected word of the line.
  - Latency 0 cycles after the request is presented.
- IDLE, hit write:
  - mem_resp=1 in the same cycle.
  - At the clock edge, only the enabled bytes of the selected word are written, and dirty[index] is set to 1.
  - mem_byte_enable=00 completes with no data change but still sets dirty.
- IDLE, miss:
  - Victim dirty goes to WRITEBACK; otherwise goes to ALLOCATE.
  - No mem_resp in the miss cycle.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 4'b0}, pmem_wdata = victim line.
  - All three held stable until pmem_resp, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={req tag, index, 4'b0}; held until pmem_resp.
  - On pmem_resp: line = pmem_rdata, tag updated, valid=1, dirty=0, then go to IDLE.
  - The pending request then hits on the next cycle. Miss latency = pmem latency(s) + 1 cycle.
- pmem_read and pmem_write are never both 1 in the same cycle.
- mem_read and mem_write both 1 is illegal; the cache treats it as a write.
- A request deasserted before mem_resp is illegal; behaviour is undefined and verification must not drive it.
- mem_rdata outside mem_resp is don't-care; benches must not check it.
- Arrays are flip-flop based (no SRAM macro), written only at clk edges.

Optional Feature:
- Macro: LC3B_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0], both cleared at reset.
  - hit_count increments once per mem_resp on an IDLE-cycle hit.
  - miss_count increments once per IDLE miss detection.
  - Both counters saturate at 16'hFFFF.
  - A request that misses and then hits after the fill counts as one miss and one hit.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- lc3b_types gains:
  - lc3b_cache_state_t enum {IDLE, WRITEBACK, ALLOCATE}.
  - Constant LC3B_LINE_OFFSET_W=4.
  - Constant LC3B_LINE_WORDS=8.
- Existing lc3b_word, lc3b_mem_wmask, lc3b_pmem_line and lc3b_pmem_addr are reused.
- One sub-module, lc3b_cache_ctrl: the state machine plus pmem handshake outputs.
- Datapath (arrays, tag compare, word mux, byte merge) stays in lc3b_wb_cache.

Test Plan:
1. Reset with rst_n=0 for 2 clk, then read 0x0010 → miss; pmem_read=1, pmem_address=0x0010. Return a line with word0=0xBEEF → mem_resp 1 cycle after pmem_resp, mem_rdata=0xBEEF.
2. Write 0x0012 with data 0x1234 and byte_enable=01 after line filled with 0xAAAA → mem_resp same cycle. Read 0x0012 → 0xAA34.
3. NUM_SETS=8, dirty line at 0x0010, then read 0x0090 (same index, new tag):
   - pmem_write=1 at 0x0010 carrying the modified line.
   - Then pmem_read=1 at 0x0090.
   - Never both high together.
4. Clean conflict, read 0x0020 then 0x00A0 → no pmem_write; only pmem_read at 0x00A0.
5. Assert rst_n=0 during ALLOCATE while pmem_resp is pending, then read 0x0010 → treated as miss; pmem_read reasserts.
6. With LC3B_CACHE_STATS_EN: 1 miss then 3 hits → miss_count=1, hit_count=4. Force hit_count to 0xFFFF, then hit → stays 0xFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared LC-3b memory-port types plus the cache state encoding
//               and line geometry constants used by lc3b_wb_cache.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [15:0]  lc3b_pmem_addr;

  // Byte offset within a line and number of 16-bit words per line
  localparam int LC3B_LINE_OFFSET_W = 4;
  localparam int LC3B_LINE_WORDS    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } lc3b_cache_state_t;

endpackage
`default_nettype wire

// File: rtl/lc3b_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_cache_ctrl
// Description : Miss-handling state machine for the write-back cache. Owns
//               the pmem handshake: victim write-back, then line allocate.
//               All pmem outputs are registered and held until pmem_resp.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3b_cache_ctrl
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         hit,
  input  logic         victim_dirty,
  input  logic [15:0]  victim_addr,
  input  logic [15:0]  req_addr,
  input  logic [127:0] victim_line,
  input  logic         pmem_resp,
  output logic         idle,
  output logic         fill,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata
);

  lc3b_cache_state_t state;

  assign idle = (state == IDLE);
  // The line is written from pmem_rdata on the cycle the allocate completes
  assign fill = (state == ALLOCATE) && pmem_resp;

  // State register and registered pmem handshake; a reset abandons any
  // outstanding transaction and a later pmem_resp lands in IDLE, where it is ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !hit) begin
            if (victim_dirty) begin
              state        <= WRITEBACK;
              pmem_write   <= 1'b1;
              pmem_address <= lc3b_pmem_addr'(victim_addr);
              pmem_wdata   <= victim_line;
            end else begin
              state        <= ALLOCATE;
              pmem_read    <= 1'b1;
              pmem_address <= lc3b_pmem_addr'(req_addr);
            end
          end
        end
        WRITEBACK: begin
          // Write strobe drops on the same edge the read strobe rises,
          // so the two are never high together
          if (pmem_resp) begin
            state        <= ALLOCATE;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= lc3b_pmem_addr'(req_addr);
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            state     <= IDLE;
            pmem_read <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lc3b_wb_cache.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_wb_cache
// Description : Direct-mapped, write-back, write-allocate cache between the
//               LC-3b cpu memory port and physical memory. 128-bit lines.
//               Hits complete combinationally in the request cycle; misses
//               go through lc3b_cache_ctrl and then hit on the next cycle.
//               Optional LC3B_CACHE_STATS_EN adds saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3b_wb_cache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 12 - IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata
`ifdef LC3B_CACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int WSEL_W = $clog2(LC3B_LINE_WORDS);

  // Storage arrays (flip-flops)
  lc3b_pmem_line       data_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  // Address split
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] word_sel;
  logic              unused_addr_bit;

  assign req_tag         = mem_address[15 -: TAG_W];
  assign req_idx         = mem_address[LC3B_LINE_OFFSET_W +: IDX_W];
  assign word_sel        = mem_address[LC3B_LINE_OFFSET_W-1:1];
  assign unused_addr_bit = mem_address[0];

  logic          req;
  logic          hit;
  logic          idle;
  logic          fill;
  logic          write_hit;
  lc3b_pmem_line cur_line;
  lc3b_word      cur_word;
  lc3b_word      merged_word;
  lc3b_mem_wmask wmask;

  assign req       = mem_read | mem_write;
  assign wmask     = mem_byte_enable;
  assign cur_line  = data_q[req_idx];
  assign cur_word  = cur_line[{word_sel, 4'b0000} +: 16];
  assign hit       = req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Hits answer in the request cycle; read+write together is taken as a write
  assign mem_resp  = idle && hit;
  assign mem_rdata = cur_word;
  assign write_hit = mem_resp && mem_write;

  // Byte merge of write data into the currently addressed word
  always_comb begin
    merged_word = cur_word;
    if (wmask[0]) merged_word[7:0]  = mem_wdata[7:0];
    if (wmask[1]) merged_word[15:8] = mem_wdata[15:8];
  end

  // Line data and tag update: whole-line replace on fill, word merge on write hit
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[req_idx] <= pmem_rdata;
      tag_q[req_idx]  <= req_tag;
    end else if (write_hit) begin
      data_q[req_idx][{word_sel, 4'b0000} +: 16] <= merged_word;
    end
  end

  // Valid/dirty bookkeeping; a write hit marks dirty even with no bytes enabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  lc3b_cache_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .hit          (hit),
    .victim_dirty (valid_q[req_idx] & dirty_q[req_idx]),
    .victim_addr  ({tag_q[req_idx], req_idx, 4'b0000}),
    .req_addr     ({mem_address[15:4], 4'b0000}),
    .victim_line  (cur_line),
    .pmem_resp    (pmem_resp),
    .idle         (idle),
    .fill         (fill),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata)
  );

`ifdef LC3B_CACHE_STATS_EN
  logic miss_det;
  assign miss_det = idle && req && !hit;

  // Saturating hit/miss counters; a refilled request counts one miss and one hit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (mem_resp && (hit_count != 16'hFFFF))   hit_count  <= hit_count + 16'd1;
      if (miss_det && (miss_count != 16'hFFFF))  miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc3b_wb_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3b_wb_cache
// Description : Self-checking bench for lc3b_wb_cache: directed vector table,
//               reset-during-allocate sequence, random traffic against a flat
//               memory model with a per-set tag model, optional stats checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3b_wb_cache;

  localparam int NSETS = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
`ifdef LC3B_CACHE_STATS_EN
  logic [15:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lc3b_wb_cache #(.NUM_SETS(NSETS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata)
`ifdef LC3B_CACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  int checks = 0;
  int passes = 0;

  // Backing memory and cpu-visible reference memory (word addressed)
  logic [15:0] pmem    [32768];
  logic [15:0] ref_mem [32768];

  // Per-set model of what the cache holds
  bit m_valid [NSETS];
  int m_tag   [NSETS];
  bit m_dirty [NSETS];

  bit          auto_resp;
  int          resp_cnt;
  logic [15:0] resp_a0;

  // Per-request observations
  bit          r_hit0, r_wb, r_fill, r_both, r_lat_ok, r_timeout;
  logic [15:0] r_rdata, r_wb_addr, r_fill_addr;
  int          alloc_cyc;

  typedef struct {
    bit          wr;
    bit          also_rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    bit          exp_hit;
    bit          exp_wb;
    logic [15:0] exp_wb_addr;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Physical memory responder: 1..3 cycle latency, checks write-back content
  initial begin
    resp_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (auto_resp) begin
        pmem_resp = 1'b0;
        if (!rst_n) resp_cnt = 0;
        else if (pmem_read || pmem_write) begin
          if (resp_cnt == 0) begin
            resp_cnt = $urandom_range(1, 3);
            resp_a0  = pmem_address;
          end
          resp_cnt--;
          if (resp_cnt == 0) begin
            logic [127:0] line;
            int base;
            chk("pmem_addr_stable", pmem_address, resp_a0);
            base = int'(pmem_address) / 2;
            if (pmem_write) begin
              for (int w = 0; w < 8; w++) line[w*16 +: 16] = ref_mem[base + w];
              chk("wb_data", pmem_wdata, line);
              for (int w = 0; w < 8; w++) pmem[base + w] = pmem_wdata[w*16 +: 16];
            end else begin
              for (int w = 0; w < 8; w++) line[w*16 +: 16] = pmem[base + w];
              pmem_rdata = line;
            end
            pmem_resp = 1'b1;
          end
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Present one request (caller sits just after a rising edge) and observe it
  task automatic do_req(input bit wr, input bit also_rd, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be);
    bit got;
    int n;
    mem_read = !wr || also_rd;
    mem_write = wr;
    mem_address = addr;
    mem_wdata = wd;
    mem_byte_enable = be;
    got = 0; n = 0;
    r_hit0 = 0; r_wb = 0; r_fill = 0; r_both = 0; r_lat_ok = 0;
    r_rdata = '0; r_wb_addr = '0; r_fill_addr = '0; alloc_cyc = -100;
    while (!got && n < 60) begin
      @(negedge clk);
      if (pmem_read && pmem_write) r_both = 1;
      if (pmem_write) begin r_wb = 1; r_wb_addr = pmem_address; end
      if (pmem_read) begin r_fill = 1; r_fill_addr = pmem_address; end
      if (pmem_resp && pmem_read) alloc_cyc = cyc;
      if (mem_resp) begin
        got = 1;
        r_rdata = mem_rdata;
        if (n == 0) r_hit0 = 1;
        else r_lat_ok = (cyc == alloc_cyc + 1);
      end
      n++;
    end
    r_timeout = !got;
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  // Request checked against the model; model advances afterwards
  task automatic run_req(input bit wr, input bit also_rd, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
    int s, t, wi;
    bit e_hit, e_wb;
    logic [15:0] e_wba, e_rd;
    s = (int'(addr) / 16) % NSETS;
    t = int'(addr) / (16 * NSETS);
    wi = int'(addr) / 2;
    e_hit = m_valid[s] && (m_tag[s] == t);
    e_wb = !e_hit && m_valid[s] && m_dirty[s];
    e_wba = 16'(m_tag[s] * 16 * NSETS + s * 16);
    e_rd = ref_mem[wi];
    do_req(wr, also_rd, addr, wd, be);
    chk("no_timeout", r_timeout, 0);
    chk("hit_in_cycle", r_hit0, e_hit);
    chk("writeback_seen", r_wb, e_wb);
    if (e_wb) chk("writeback_addr", r_wb_addr, e_wba);
    chk("fill_seen", r_fill, !e_hit);
    if (!e_hit) begin
      chk("fill_addr", r_fill_addr, addr & 16'hFFF0);
      chk("miss_latency", r_lat_ok, 1);
    end
    chk("pmem_rw_exclusive", r_both, 0);
    if (!wr) chk("rdata", r_rdata, e_rd);
    if (!e_hit) begin
      m_valid[s] = 1; m_tag[s] = t; m_dirty[s] = 0;
    end
    if (wr) begin
      m_dirty[s] = 1;
      if (be[0]) ref_mem[wi][7:0] = wd[7:0];
      if (be[1]) ref_mem[wi][15:8] = wd[15:8];
    end
  endtask

  task automatic model_restart();
    for (int i = 0; i < 32768; i++) ref_mem[i] = pmem[i];
    for (int i = 0; i < NSETS; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_restart();
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
    mem_address = 0; mem_wdata = 0; pmem_resp = 0; pmem_rdata = '0; auto_resp = 1;

    for (int i = 0; i < 32768; i++) pmem[i] = 16'(i * 2) ^ 16'h5A5A;
    pmem[8] = 16'hBEEF;
    for (int i = 9; i < 16; i++) pmem[i] = 16'hAAAA;

    //            wr also addr      wdata     be     hit wb wb_addr   rdata
    vecs[0]  = '{0, 0, 16'h0010, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'hBEEF};
    vecs[1]  = '{1, 0, 16'h0012, 16'h1234, 2'b01, 1, 0, 16'h0000, 16'h0000};
    vecs[2]  = '{0, 0, 16'h0012, 16'h0000, 2'b00, 1, 0, 16'h0000, 16'hAA34};
    vecs[3]  = '{0, 0, 16'h0090, 16'h0000, 2'b00, 0, 1, 16'h0010, 16'h5ACA};
    vecs[4]  = '{0, 0, 16'h0010, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'hBEEF};
    vecs[5]  = '{0, 0, 16'h0012, 16'h0000, 2'b00, 1, 0, 16'h0000, 16'hAA34};
    vecs[6]  = '{0, 0, 16'h0020, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h5A7A};
    vecs[7]  = '{0, 0, 16'h00A0, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h5AFA};
    vecs[8]  = '{1, 0, 16'h00A4, 16'hCAFE, 2'b00, 1, 0, 16'h0000, 16'h0000};
    vecs[9]  = '{0, 0, 16'h00A4, 16'h0000, 2'b00, 1, 0, 16'h0000, 16'h5AFE};
    vecs[10] = '{0, 0, 16'h0020, 16'h0000, 2'b00, 0, 1, 16'h00A0, 16'h5A7A};
    vecs[11] = '{1, 1, 16'h0026, 16'hBBCC, 2'b10, 1, 0, 16'h0000, 16'h0000};
    vecs[12] = '{0, 0, 16'h0026, 16'h0000, 2'b00, 1, 0, 16'h0000, 16'hBB7C};

    @(posedge clk); #1;
    do_reset();

    chk("reset_mem_resp", mem_resp, 0);
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_pmem_write", pmem_write, 0);
    chk("reset_pmem_address", pmem_address, 16'h0000);
    chk("reset_pmem_wdata", pmem_wdata, 128'h0);
`ifdef LC3B_CACHE_STATS_EN
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);
`endif

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_req(vecs[i].wr, vecs[i].also_rd, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      chk($sformatf("vec%0d_hit", i), r_hit0, vecs[i].exp_hit);
      chk($sformatf("vec%0d_wb", i), r_wb, vecs[i].exp_wb);
      if (vecs[i].exp_wb) chk($sformatf("vec%0d_wb_addr", i), r_wb_addr, vecs[i].exp_wb_addr);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), r_rdata, vecs[i].exp_rdata);
    end

    // Reset in the middle of an allocate; late pmem_resp must be ignored
    auto_resp = 0;
    mem_read = 1; mem_write = 0; mem_address = 16'h0110;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pmem_read_up", pmem_read, 1);
    chk("abort_pmem_write_low", pmem_write, 0);
    chk("abort_pmem_addr", pmem_address, 16'h0110);
    @(posedge clk); #1;
    rst_n = 0; mem_read = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pmem_read_dropped", pmem_read, 0);
    chk("abort_pmem_addr_cleared", pmem_address, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1; pmem_resp = 1; pmem_rdata = {8{16'hDEAD}};
    @(posedge clk); #1;
    pmem_resp = 0;
    @(negedge clk);
    chk("late_resp_no_read", pmem_read, 0);
    chk("late_resp_no_write", pmem_write, 0);
    @(posedge clk); #1;
    model_restart();
    auto_resp = 1;
    run_req(0, 0, 16'h0010, 16'h0, 2'b00);

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      logic [15:0] a;
      bit w;
      a = 16'($urandom_range(0, 511)) & 16'hFFFE;
      if ($urandom_range(0, 7) == 0) a = 16'($urandom) & 16'hFFFE;
      w = ($urandom_range(0, 9) < 4);
      run_req(w, 1'b0, a, 16'($urandom), 2'($urandom));
    end

`ifdef LC3B_CACHE_STATS_EN
    do_reset();
    chk("stats_clear_hit", hit_count, 0);
    chk("stats_clear_miss", miss_count, 0);
    run_req(0, 0, 16'h0030, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) run_req(0, 0, 16'h0030, 16'h0, 2'b00);
    chk("stats_miss_1", miss_count, 1);
    chk("stats_hit_4", hit_count, 4);
    for (int i = 0; i < 65531; i++) do_req(0, 0, 16'h0030, 16'h0, 2'b00);
    chk("stats_hit_full", hit_count, 16'hFFFF);
    do_req(0, 0, 16'h0030, 16'h0, 2'b00);
    chk("stats_hit_saturated", hit_count, 16'hFFFF);
    chk("stats_miss_still_1", miss_count, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
